pipe_drain_fifo: RTL

PIPE_DRAIN_FIFO -- requirements
Module: pipe_drain_fifo

---
 rtl/pipe_pkg.sv | 13 +
 rtl/fifo_mem.sv | 25 ++
 rtl/pipe_drain_fifo.sv | 100 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared defaults and sizing helpers for the pipeline drain FIFO.
package pipe_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 10;
    localparam int unsigned DEF_DEPTH      = 16;
    localparam int unsigned DEF_LATENCY    = 10;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register file: synchronous write, combinational read.
module fifo_mem #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                     clk_in,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage is intentionally left unreset.
    always_ff @(posedge clk_in) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_drain_fifo.sv
// FWFT FIFO draining a fixed-latency pipeline, with credit-based issue control
// so that an upstream honouring issue_ready_out can never overflow it.
module pipe_drain_fifo
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned LATENCY    = DEF_LATENCY
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        issue_in,
    output logic                        issue_ready_out,
    input  logic                        valid_in,
    input  logic [DATA_WIDTH-1:0]       data_in,
    output logic                        valid_out,
    output logic [DATA_WIDTH-1:0]       data_out,
    input  logic                        ready_in,
    output logic [cnt_w(DEPTH)-1:0]     count_out,
    output logic                        overflow_out
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);

    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_nxt;
    logic [CW-1:0]         inflight_q;
    logic [CW-1:0]         inflight_nxt;
    logic                  valid_q;
    logic                  overflow_q;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic [DATA_WIDTH-1:0] rd_data;

    assign full = (count_q == CW'(DEPTH));
    assign pop  = valid_q & ready_in;
    assign push = valid_in & (~full | pop);
    assign drop = valid_in & full & ~pop;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk_in (clk_in),
        .we     (push),
        .waddr  (wr_ptr_q),
        .wdata  (data_in),
        .raddr  (rd_ptr_q),
        .rdata  (rd_data)
    );

    // Next stored count and in-flight credit count.
    always_comb begin
        count_nxt    = count_q;
        inflight_nxt = inflight_q;
        case ({push, pop})
            2'b10:   count_nxt = count_q + CW'(1);
            2'b01:   count_nxt = count_q - CW'(1);
            default: count_nxt = count_q;
        endcase
        // Saturate at DEPTH on illegal issue and at 0 on unexpected arrival.
        case ({issue_in, valid_in})
            2'b10: if (inflight_q != CW'(DEPTH)) inflight_nxt = inflight_q + CW'(1);
            2'b01: if (inflight_q != CW'(0))     inflight_nxt = inflight_q - CW'(1);
            default: inflight_nxt = inflight_q;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            // A legal upstream never has more words in flight than pipeline stages.
            assert (32'(inflight_q) <= LATENCY);
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q    <= count_nxt;
            inflight_q <= inflight_nxt;
            valid_q    <= (count_nxt != CW'(0));
            if (drop) overflow_q <= 1'b1;
        end
    end

    assign issue_ready_out = (({1'b0, count_q} + {1'b0, inflight_q}) < (CW + 1)'(DEPTH));
    assign valid_out       = valid_q;
    assign data_out        = valid_q ? rd_data : '0;
    assign count_out       = count_q;
    assign overflow_out    = overflow_q;

endmodule
